// File: rtl/merger_pkg.sv
// Shared types and helpers for the merger-tree output stage.
package merger_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Key is the top kw bits of a dw-bit record (dw, kw <= 64).
    function automatic logic [63:0] rec_key(input logic [63:0] rec,
                                            input int unsigned dw,
                                            input int unsigned kw);
        logic [63:0] mask;
        mask = ~64'd0 >> (64 - kw);
        return (rec >> (dw - kw)) & mask;
    endfunction

    function automatic int unsigned pack_ratio(input int unsigned beat_recs,
                                               input int unsigned p);
        return beat_recs / p;
    endfunction

endpackage

// File: rtl/packer_fifo.sv
// Small synchronous FIFO for packed output beats; accepts enqueue while full
// when a dequeue happens in the same cycle.
module packer_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_enq,
    input  logic [W-1:0] i_enq_data,
    input  logic         i_deq,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          enq_ok, deq_ok;

    assign o_full  = (cnt_q == (AW+1)'(DEPTH));
    assign o_empty = (cnt_q == '0);
    assign deq_ok  = i_deq & ~o_empty;
    assign enq_ok  = i_enq & (~o_full | deq_ok);
    // Data is forced to zero when empty so nothing stale leaks out.
    assign o_data  = o_empty ? '0 : mem_q[rd_q];

    always_comb begin
        cnt_d = cnt_q;
        if (enq_ok & ~deq_ok)
            cnt_d = cnt_q + (AW+1)'(1);
        else if (~enq_ok & deq_ok)
            cnt_d = cnt_q - (AW+1)'(1);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (enq_ok) begin
                mem_q[wr_q] <= i_enq_data;
                wr_q        <= wr_q + AW'(1);
            end
            if (deq_ok)
                rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/merger_output_packer.sv
// Packs root-merger beats into wide write beats with run tracking.
// Optional key-order checker: define MERGER_OUTPUT_PACKER_ORDER_CHECK_EN.
module merger_output_packer
    import merger_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int KEY_WIDTH  = 32,
    parameter int P          = 8,
    parameter int BEAT_RECS  = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 32
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_start,
    input  logic [CNT_W-1:0]                i_total_beats,
    input  logic [P*DATA_WIDTH-1:0]         i_data,
    input  logic                            i_write,
    output logic                            o_ready,
    output logic [BEAT_RECS*DATA_WIDTH-1:0] o_out_data,
    output logic                            o_out_valid,
    output logic                            o_out_last,
    input  logic                            i_out_ready,
    output logic                            o_done
`ifdef MERGER_OUTPUT_PACKER_ORDER_CHECK_EN
    ,
    output logic                            o_order_err
`endif
);
    localparam int unsigned K     = pack_ratio(BEAT_RECS, P);
    localparam int          LW    = (K > 1) ? $clog2(K) : 1;
    localparam int          IN_W  = P * DATA_WIDTH;
    localparam int          OUT_W = BEAT_RECS * DATA_WIDTH;
    localparam logic [LW-1:0] LANE_LAST = LW'(K - 1);

    if (KEY_WIDTH > DATA_WIDTH || (BEAT_RECS % P) != 0 || K < 1)
        $error("merger_output_packer: bad KEY_WIDTH/P/BEAT_RECS combination");

    state_e           state_q, state_d;
    logic [LW-1:0]    lane_q, lane_d;
    logic [CNT_W-1:0] beat_q, beat_d, total_q, total_d;
    logic [OUT_W-1:0] pack_q, pack_d, pack_w;
    logic             accept, deq, last_in, start_take;
    logic             fifo_enq, fifo_full, fifo_empty;
    logic [OUT_W:0]   fifo_wdata, fifo_rdata;

    assign deq        = ~fifo_empty & i_out_ready;
    assign o_ready    = (state_q == RUN) & ((lane_q != LANE_LAST) | ~fifo_full | deq);
    assign accept     = i_write & o_ready;
    assign last_in    = ((beat_q + CNT_W'(1)) == total_q);
    assign start_take = i_start & ((state_q == IDLE) | (state_q == DONE));

    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        beat_d     = beat_q;
        total_d    = total_q;
        pack_d     = pack_q;
        fifo_enq   = 1'b0;
        fifo_wdata = {1'b0, pack_q};
        pack_w     = pack_q;
        pack_w[IN_W*lane_q +: IN_W] = i_data;

        case (state_q)
            IDLE, DONE: begin
                if (i_start) begin
                    total_d = i_total_beats;
                    beat_d  = '0;
                    lane_d  = '0;
                    pack_d  = '0;
                    state_d = (i_total_beats == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    beat_d = beat_q + CNT_W'(1);
                    // Completing a pack enqueues it in the same cycle and clears
                    // the register so a later partial flush is zero-padded.
                    if (lane_q == LANE_LAST) begin
                        fifo_enq   = 1'b1;
                        fifo_wdata = {last_in, pack_w};
                        pack_d     = '0;
                        lane_d     = '0;
                    end else begin
                        pack_d = pack_w;
                        lane_d = lane_q + LW'(1);
                    end
                    if (last_in)
                        state_d = (lane_q == LANE_LAST) ? DONE : FLUSH;
                end
            end
            FLUSH: begin
                fifo_wdata = {1'b1, pack_q};
                if (~fifo_full | deq) begin
                    fifo_enq = 1'b1;
                    pack_d   = '0;
                    lane_d   = '0;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            lane_q  <= '0;
            beat_q  <= '0;
            total_q <= '0;
            pack_q  <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            beat_q  <= beat_d;
            total_q <= total_d;
            pack_q  <= pack_d;
        end
    end

    packer_fifo #(
        .W     (OUT_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_enq      (fifo_enq),
        .i_enq_data (fifo_wdata),
        .i_deq      (deq),
        .o_data     (fifo_rdata),
        .o_full     (fifo_full),
        .o_empty    (fifo_empty)
    );

    assign o_out_valid = ~fifo_empty;
    assign o_out_data  = fifo_rdata[OUT_W-1:0];
    assign o_out_last  = fifo_rdata[OUT_W];
    assign o_done      = (state_q == DONE);

`ifdef MERGER_OUTPUT_PACKER_ORDER_CHECK_EN
    logic [KEY_WIDTH-1:0] prev_key_q, k_cur, k_ref;
    logic                 have_prev_q, err_q, beat_err;

    // Stream order is non-increasing; lane 0 is compared with the previous beat's last lane.
    always_comb begin
        beat_err = 1'b0;
        k_ref    = prev_key_q;
        k_cur    = '0;
        for (int i = 0; i < P; i++) begin
            k_cur = KEY_WIDTH'(rec_key(64'(i_data[i*DATA_WIDTH +: DATA_WIDTH]),
                                       DATA_WIDTH, KEY_WIDTH));
            if ((i != 0 || have_prev_q) && (k_cur > k_ref))
                beat_err = 1'b1;
            k_ref = k_cur;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prev_key_q  <= '0;
            have_prev_q <= 1'b0;
            err_q       <= 1'b0;
        end else if (start_take) begin
            have_prev_q <= 1'b0;
            err_q       <= 1'b0;
        end else if (accept) begin
            prev_key_q  <= k_ref;
            have_prev_q <= 1'b1;
            err_q       <= err_q | beat_err;
        end
    end

    assign o_order_err = err_q;
`else
    logic unused_start;
    assign unused_start = start_take;
`endif

endmodule
